// File: rtl/popcount_window_acc_if.sv
// Count-in / window-result-out handshake bundle for popcount_window_acc.
// out_over exists only when THRESHOLD_EN is defined.
interface popcount_window_acc_if #(
    parameter int CNT_W  = 6,
    parameter int WINDOW = 16,
    parameter int ACC_W  = CNT_W + $clog2(WINDOW)
);
    logic                       in_valid;
    logic                       in_ready;
    logic [CNT_W-1:0]           in_count;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_W-1:0]           out_sum;
    logic [$clog2(WINDOW):0]    out_samples;
`ifdef THRESHOLD_EN
    logic                       out_over;

    modport master (
        output in_valid, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_samples, out_over
    );
    modport slave (
        input  in_valid, in_count, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_samples, out_over
    );
`else
    modport master (
        output in_valid, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_samples
    );
    modport slave (
        input  in_valid, in_count, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_samples
    );
`endif
endinterface

// File: rtl/popcount_window_acc.sv
// Sums WINDOW popcounts (fewer when in_last closes early) into a held valid/ready result.
// Define THRESHOLD_EN to add a registered out_over = (sum >= THRESH).
module popcount_window_acc #(
    parameter int CNT_W  = 6,
    parameter int WINDOW = 16,
    parameter int ACC_W  = CNT_W + $clog2(WINDOW),
    parameter int THRESH = 256
) (
    input logic               clk,
    input logic               rst_n,
    popcount_window_acc_if.slave bus
);
    localparam int IDX_W = $clog2(WINDOW);
    localparam int SMP_W = IDX_W + 1;

    if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
        $error("WINDOW must be a power of two >= 2");
    end

    typedef enum logic [1:0] {EMPTY, ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [ACC_W-1:0]   sum_q;
    logic [SMP_W-1:0]   smp_q;
    logic               vld_q;
    logic [ACC_W-1:0]   tmp;
    logic               in_ready;
    logic               accept;
    logic               close;

    // Ready while held only if the result drains this cycle, so HOLD never bubbles.
    assign in_ready = (state_q != HOLD) | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;
    assign tmp      = acc_q + ACC_W'(bus.in_count);
    assign close    = accept & ((idx_q == IDX_W'(WINDOW - 1)) | bus.in_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY, ACCUM: begin
                if (close)       state_d = HOLD;
                else if (accept) state_d = ACCUM;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (close)       state_d = HOLD;
                    else if (accept) state_d = ACCUM;
                    else             state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            idx_q <= '0;
            sum_q <= '0;
            smp_q <= '0;
            vld_q <= 1'b0;
        end else begin
            if (close) begin
                acc_q <= '0;
                idx_q <= '0;
                sum_q <= tmp;
                smp_q <= {1'b0, idx_q} + SMP_W'(1);
            end else if (accept) begin
                acc_q <= tmp;
                idx_q <= idx_q + IDX_W'(1);
            end
            vld_q <= (state_d == HOLD);
        end
    end

`ifdef THRESHOLD_EN
    logic over_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     over_q <= 1'b0;
        else if (close) over_q <= (32'(tmp) >= $unsigned(THRESH));
    end

    assign bus.out_over = over_q;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = vld_q;
    assign bus.out_sum     = sum_q;
    assign bus.out_samples = smp_q;
endmodule

// File: tb/tb_popcount_window_acc.sv
// Directed stimulus with a result scoreboard; a negedge monitor pops on every output handshake.
module tb_popcount_window_acc;
    localparam int CNT_W  = 6;
    localparam int WINDOW = 16;
    localparam int ACC_W  = 10;
    localparam int THRESH = 256;

    typedef struct {
        int sum;
        int smp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];

    popcount_window_acc_if #(.CNT_W(CNT_W), .WINDOW(WINDOW), .ACC_W(ACC_W)) bus ();

    popcount_window_acc #(
        .CNT_W(CNT_W), .WINDOW(WINDOW), .ACC_W(ACC_W), .THRESH(THRESH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int sum, input int smp);
        exp_t e;
        e.sum = sum;
        e.smp = smp;
        sb.push_back(e);
    endtask

    // Entered and left at posedge+1; the beat is taken on the posedge in between.
    task automatic send(input int c, input bit last);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_count = CNT_W'(c);
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) chk("send_ready_timeout", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", int'(bus.out_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("out_sum", int'(bus.out_sum), e.sum);
                chk("out_samples", int'(bus.out_samples), e.smp);
`ifdef THRESHOLD_EN
                chk("out_over", int'(bus.out_over), int'(e.sum >= THRESH));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        bus.in_valid  = 1'b0;
        bus.in_count  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sum", int'(bus.out_sum), 0);
        chk("rst_out_samples", int'(bus.out_samples), 0);
`ifdef THRESHOLD_EN
        chk("rst_out_over", int'(bus.out_over), 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", int'(bus.in_ready), 1);

        // Full window of 32s, with a latency check around the closing beat.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push(512, 16);
            send(32, 1'b0);
            if (i == 14) chk("no_early_valid", int'(bus.out_valid), 0);
        end
        chk("close_latency", int'(bus.out_valid), 1);

        // Early close.
        send(5, 1'b0);
        send(0, 1'b0);
        push(12, 3);
        send(7, 1'b1);

        // in_last on beat WINDOW behaves like a natural close.
        for (int i = 0; i < 15; i++) send(2, 1'b0);
        push(32, 16);
        send(2, 1'b1);

        // Threshold boundary: exactly 256, then 255.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push(256, 16);
            send(16, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 15) push(255, 16);
            send(i == 15 ? 15 : 16, 1'b0);
        end
        idle(2);

        // Stall in HOLD; a pending beat must not be taken while out_ready=0.
        bus.out_ready = 1'b0;
        send(10, 1'b0);
        send(20, 1'b0);
        push(60, 3);
        send(30, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_count = CNT_W'(63);
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", int'(bus.in_ready), 0);
            chk("stall_out_valid", int'(bus.out_valid), 1);
            chk("stall_out_sum", int'(bus.out_sum), 60);
            chk("stall_out_samples", int'(bus.out_samples), 3);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(7, 1'b0);
        push(15, 2);
        send(8, 1'b1);

        // Back-to-back windows at full rate.
        push(136, 16);
        push(392, 16);
        push(136, 16);
        push(392, 16);
        start = cyc;
        for (int i = 0; i < 64; i++) send((i % 32) + 1, 1'b0);
        chk("no_bubble_cycles", cyc - start, 64);

        // Reset mid-window drops the partial sum.
        for (int i = 0; i < 9; i++) send(10, 1'b0);
        chk("pre_reset_valid", int'(bus.out_valid), 0);
        rst_n = 1'b0;
        #2;
        chk("in_reset_valid", int'(bus.out_valid), 0);
        chk("in_reset_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(16, 16);
        for (int i = 0; i < 16; i++) send(1, 1'b0);

        // Single-beat windows, second one taken in the release cycle.
        push(31, 1);
        send(31, 1'b1);
        push(2, 1);
        send(2, 1'b1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        idle(2);
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_out_valid", int'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
